// File: rtl/mem_ctrl.sv
// Byte-serial controller sharing one 8-bit RAM port between instruction fetch and
// load/store traffic; bursts are little-endian, loads are sign/zero extended.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [16:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        ma_re,
  input  logic        ma_we,
  input  logic [2:0]  ma_width,
  input  logic [16:0] ma_addr,
  input  logic [31:0] ma_wdata,
  output logic        ma_done,
  output logic [31:0] ma_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [16:0] mem_a,
  output logic        mem_wr
);

  // state | meaning
  // IDLE  | not servicing a request
  // IF_RD | servicing a fetch
  // MA_RD | servicing a load
  // MA_WR | servicing a store
  typedef enum logic [1:0] {IDLE, IF_RD, MA_RD, MA_WR} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  len;
  logic [16:0] ptr;
  logic [31:0] asm_q;
  logic [2:0]  width_q;
  logic        if_done_q;
  logic        ma_done_q;

  logic [2:0]  len_ma;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  logic [31:0] ext;
  logic        rd_state;

  assign rd_state = (state == IF_RD) || (state == MA_RD);
  assign len_ma   = (ma_width[1:0] == 2'b00) ? 3'd1 :
                    (ma_width[1:0] == 2'b01) ? 3'd2 : 3'd4;

  // During a read, cnt counts cycles into the burst: byte cnt-1 arrives on mem_din
  // while byte cnt is being addressed.
  always_comb begin
    byte_idx = cnt[1:0] - 2'd1;
    word     = asm_q;
    word[{byte_idx, 3'b000} +: 8] = mem_din;
    case (width_q)
      3'b000:  ext = {{24{word[7]}}, word[7:0]};
      3'b100:  ext = {24'h000000, word[7:0]};
      3'b001:  ext = {{16{word[15]}}, word[15:0]};
      3'b101:  ext = {16'h0000, word[15:0]};
      default: ext = word;
    endcase
  end

  // On a stall, step back to the byte whose data has not been captured yet so
  // mem_din carries it again in the first ready cycle.
  assign mem_a    = (!rdy && rd_state && cnt != 3'd0 && cnt != len) ? ptr - 17'd1 : ptr;
  assign mem_wr   = (state == MA_WR) && rdy;
  assign mem_dout = (state == MA_WR) ? asm_q[7:0] : 8'h00;
  assign if_done  = if_done_q && rdy;
  assign ma_done  = ma_done_q && rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      len       <= 3'd0;
      ptr       <= 17'd0;
      asm_q     <= 32'd0;
      width_q   <= 3'd0;
      if_done_q <= 1'b0;
      ma_done_q <= 1'b0;
      if_inst   <= 32'd0;
      ma_rdata  <= 32'd0;
    end else if (rdy) begin
      if_done_q <= 1'b0;
      ma_done_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (ma_we) begin
            state <= MA_WR;
            ptr   <= ma_addr;
            len   <= len_ma;
            asm_q <= ma_wdata;
          end else if (ma_re) begin
            state   <= MA_RD;
            ptr     <= ma_addr;
            len     <= len_ma;
            width_q <= ma_width;
            asm_q   <= 32'd0;
          end else if (if_req) begin
            state <= IF_RD;
            ptr   <= if_addr;
            len   <= 3'd4;
            asm_q <= 32'd0;
          end
        end
        IF_RD, MA_RD: begin
          if (cnt != 3'd0) asm_q[{byte_idx, 3'b000} +: 8] <= mem_din;
          if (cnt == len) begin
            state <= IDLE;
            cnt   <= 3'd0;
            if (state == IF_RD) begin
              if_inst   <= word;
              if_done_q <= 1'b1;
            end else begin
              ma_rdata  <= ext;
              ma_done_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 3'd1;
            if (cnt + 3'd1 < len) ptr <= ptr + 17'd1;
          end
        end
        MA_WR: begin
          if (cnt + 3'd1 == len) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            ma_done_q <= 1'b1;
          end else begin
            cnt   <= cnt + 3'd1;
            ptr   <= ptr + 17'd1;
            asm_q <= {8'h00, asm_q[31:8]};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-wide RAM model, expected results taken
// from a byte-array memory image updated by the store rules.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [16:0] if_addr = 17'd0;
  logic        if_done;
  logic [31:0] if_inst;
  logic        ma_re = 1'b0;
  logic        ma_we = 1'b0;
  logic [2:0]  ma_width = 3'd0;
  logic [16:0] ma_addr = 17'd0;
  logic [31:0] ma_wdata = 32'd0;
  logic        ma_done;
  logic [31:0] ma_rdata;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [16:0] mem_a;
  logic        mem_wr;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram [131072] = '{default: 8'h00};
  logic [7:0]  model_mem [131072];
  logic [16:0] log_a [0:40];
  logic        log_wr [0:40];
  logic [7:0]  log_dout [0:40];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .ma_re(ma_re), .ma_we(ma_we), .ma_width(ma_width), .ma_addr(ma_addr),
    .ma_wdata(ma_wdata), .ma_done(ma_done), .ma_rdata(ma_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_din <= ram[mem_a];
    if (mem_wr) ram[mem_a] <= mem_dout;
  end

  function automatic int nbytes(input logic [2:0] w);
    return (w[1:0] == 2'b00) ? 1 : (w[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [16:0] addr, input logic [2:0] w);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < nbytes(w); i++) v[8*i +: 8] = model_mem[addr + 17'(i)];
    case (w)
      3'b000:  return 32'($signed(v[7:0]));
      3'b001:  return 32'($signed(v[15:0]));
      3'b100:  return {24'd0, v[7:0]};
      3'b101:  return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  task automatic ref_store(input logic [16:0] addr, input logic [2:0] w, input logic [31:0] d);
    for (int i = 0; i < nbytes(w); i++) model_mem[addr + 17'(i)] = d[8*i +: 8];
  endtask

  // kind: 0 fetch, 1 load, 2 store. Starts at a negedge, returns at the negedge of
  // the done cycle (cyc = 0 if done never came). low_mask bit c drops rdy in cycle c.
  task automatic run_op(input int kind, input logic [16:0] addr, input logic [2:0] w,
                        input logic [31:0] d, input logic [31:0] low_mask, input bit hold_if,
                        output int cyc, output int lows, output logic [31:0] res, output bit other);
    cyc = 0; lows = 0; res = 32'd0; other = 1'b0;
    case (kind)
      0: begin if_req = 1'b1; if_addr = addr; end
      1: begin ma_re = 1'b1; ma_addr = addr; ma_width = w; end
      default: begin ma_we = 1'b1; ma_addr = addr; ma_width = w; ma_wdata = d; end
    endcase
    if (hold_if) if_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1 rdy = (c < 32) ? ~low_mask[c] : 1'b1;
      @(negedge clk);
      log_a[c] = mem_a; log_wr[c] = mem_wr; log_dout[c] = mem_dout;
      if (!rdy) lows++;
      if (kind == 0 ? ma_done : if_done) other = 1'b1;
      if (kind == 0 ? if_done : ma_done) begin
        cyc = c;
        res = (kind == 0) ? if_inst : ma_rdata;
        break;
      end
    end
    rdy = 1'b1;
    ma_re = 1'b0; ma_we = 1'b0;
    if (!hold_if || kind == 0) if_req = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 131072; i++) model_mem[i] = 8'h00;
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({if_done, ma_done, if_inst, ma_rdata, mem_a, mem_dout, mem_wr} !== 93'd0) begin
      errors++;
      $display("FAIL reset_outputs: got if_inst=%h ma_rdata=%h mem_a=%h dout=%h wr=%b done=%b%b expected all zero",
               if_inst, ma_rdata, mem_a, mem_dout, mem_wr, if_done, ma_done);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch;
    int cyc, lows; logic [31:0] res; bit other;
    run_op(2, 17'h00100, 3'b010, 32'h00000513, 32'd0, 1'b0, cyc, lows, res, other);
    ref_store(17'h00100, 3'b010, 32'h00000513);
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL word_store_latency: got %0d expected 5", cyc); end
    run_op(0, 17'h00100, 3'b000, 32'd0, 32'd0, 1'b0, cyc, lows, res, other);
    checks++;
    if (cyc !== 6) begin errors++; $display("FAIL fetch_latency: got %0d expected 6", cyc); end
    checks++;
    if (res !== ref_load(17'h00100, 3'b010)) begin
      errors++; $display("FAIL fetch_inst: got %h expected %h", res, ref_load(17'h00100, 3'b010));
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (log_a[i] !== 17'h00100 + 17'(i - 1)) begin
        errors++; $display("FAIL fetch_addr_c%0d: got %h expected %h", i, log_a[i], 17'h00100 + 17'(i - 1));
      end
    end
    checks++;
    if ({log_wr[1], log_wr[2], log_wr[3], log_wr[4], log_wr[5], log_wr[6]} !== 6'b0) begin
      errors++; $display("FAIL fetch_no_write: got a write during a fetch expected none");
    end
    @(negedge clk);
    checks++;
    if (if_done !== 1'b0) begin errors++; $display("FAIL fetch_done_pulse: got if_done=%b in cycle 7 expected 0", if_done); end
  endtask

  task automatic test_arbitration;
    int cyc, lows; logic [31:0] res, expv; bit other;
    logic [2:0] wl [2];
    wl[0] = 3'b000; wl[1] = 3'b100;
    run_op(2, 17'h00010, 3'b000, 32'h12345680, 32'd0, 1'b0, cyc, lows, res, other);
    ref_store(17'h00010, 3'b000, 32'h12345680);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL byte_store_latency: got %0d expected 2", cyc); end
    for (int k = 0; k < 2; k++) begin
      if_addr = 17'h00100;
      run_op(1, 17'h00010, wl[k], 32'd0, 32'd0, 1'b1, cyc, lows, res, other);
      expv = ref_load(17'h00010, wl[k]);
      checks++;
      if (cyc !== 3 || res !== expv || other || log_a[1] !== 17'h00010) begin
        errors++;
        $display("FAIL arb_load_w%0d: got cyc=%0d data=%h if_done_seen=%b a1=%h expected cyc=3 data=%h none a1=00010",
                 k, cyc, res, other, log_a[1], expv);
      end
      run_op(0, 17'h00100, 3'b000, 32'd0, 32'd0, 1'b0, cyc, lows, res, other);
      checks++;
      if (cyc !== 6 || res !== ref_load(17'h00100, 3'b010) || log_a[1] !== 17'h00100) begin
        errors++;
        $display("FAIL arb_fetch_after_load%0d: got cyc=%0d inst=%h a1=%h expected cyc=6 inst=%h a1=00100",
                 k, cyc, res, log_a[1], ref_load(17'h00100, 3'b010));
      end
    end
  endtask

  task automatic test_store_wrap;
    int cyc, lows; logic [31:0] res; bit other;
    run_op(2, 17'h1FFFF, 3'b001, 32'hDEADBEEF, 32'd0, 1'b0, cyc, lows, res, other);
    ref_store(17'h1FFFF, 3'b001, 32'hDEADBEEF);
    checks++;
    if (cyc !== 3) begin errors++; $display("FAIL wrap_store_latency: got %0d expected 3", cyc); end
    checks++;
    if ({log_wr[1], log_a[1], log_dout[1]} !== {1'b1, 17'h1FFFF, 8'hEF}) begin
      errors++; $display("FAIL wrap_byte0: got wr=%b a=%h d=%h expected 1 1ffff ef", log_wr[1], log_a[1], log_dout[1]);
    end
    checks++;
    if ({log_wr[2], log_a[2], log_dout[2]} !== {1'b1, 17'h00000, 8'hBE}) begin
      errors++; $display("FAIL wrap_byte1: got wr=%b a=%h d=%h expected 1 00000 be", log_wr[2], log_a[2], log_dout[2]);
    end
    checks++;
    if (log_wr[3] !== 1'b0 || ram[17'h00001] !== model_mem[17'h00001]) begin
      errors++; $display("FAIL wrap_no_third: got wr=%b ram[1]=%h expected 0 %h", log_wr[3], ram[17'h00001], model_mem[17'h00001]);
    end
  endtask

  task automatic test_rdy_pause;
    int cyc, lows; logic [31:0] res, d; bit other; bit anywr;
    d = $urandom;
    run_op(2, 17'h00200, 3'b010, d, 32'd0, 1'b0, cyc, lows, res, other);
    ref_store(17'h00200, 3'b010, d);
    run_op(1, 17'h00200, 3'b010, 32'd0, 32'h38, 1'b0, cyc, lows, res, other);
    anywr = 1'b0;
    for (int i = 1; i <= 9; i++) if (log_wr[i]) anywr = 1'b1;
    checks++;
    if (cyc !== 9 || res !== ref_load(17'h00200, 3'b010)) begin
      errors++; $display("FAIL pause_load: got cyc=%0d data=%h expected cyc=9 data=%h", cyc, res, ref_load(17'h00200, 3'b010));
    end
    checks++;
    if (anywr) begin errors++; $display("FAIL pause_no_write: got mem_wr=1 during load expected 0"); end
    checks++;
    if (log_a[3] !== 17'h00201 || log_a[5] !== 17'h00201 || log_a[6] !== 17'h00202) begin
      errors++; $display("FAIL pause_addr: got %h %h %h expected 00201 00201 00202", log_a[3], log_a[5], log_a[6]);
    end
    d = $urandom;
    run_op(2, 17'h00300, 3'b110, d, 32'h4, 1'b0, cyc, lows, res, other);
    ref_store(17'h00300, 3'b110, d);
    checks++;
    if (cyc !== 6 || log_wr[2] !== 1'b0 || {log_wr[3], log_a[3], log_dout[3]} !== {1'b1, 17'h00301, d[15:8]}) begin
      errors++; $display("FAIL pause_store: got cyc=%0d wr2=%b a3=%h d3=%h expected 6 0 00301 %h", cyc, log_wr[2], log_a[3], log_dout[3], d[15:8]);
    end
    run_op(1, 17'h00300, 3'b010, 32'd0, 32'd0, 1'b0, cyc, lows, res, other);
    checks++;
    if (res !== ref_load(17'h00300, 3'b010)) begin
      errors++; $display("FAIL pause_store_readback: got %h expected %h", res, ref_load(17'h00300, 3'b010));
    end
  endtask

  task automatic test_back_to_back;
    int cyc, lows; logic [31:0] res, d; bit other;
    for (int k = 0; k < 3; k++) begin
      run_op(0, 17'h00100 + 17'(4 * k), 3'b000, 32'd0, 32'd0, 1'b0, cyc, lows, res, other);
      checks++;
      if (cyc !== 6 || res !== ref_load(17'h00100 + 17'(4 * k), 3'b010)) begin
        errors++; $display("FAIL b2b_fetch%0d: got cyc=%0d inst=%h expected 6 %h", k, cyc, res, ref_load(17'h00100 + 17'(4 * k), 3'b010));
      end
    end
    d = $urandom;
    run_op(2, 17'h00501, 3'b001, d, 32'd0, 1'b0, cyc, lows, res, other);
    ref_store(17'h00501, 3'b001, d);
    run_op(1, 17'h00501, 3'b001, 32'd0, 32'd0, 1'b0, cyc, lows, res, other);
    checks++;
    if (cyc !== 4 || res !== ref_load(17'h00501, 3'b001)) begin
      errors++; $display("FAIL b2b_store_load: got cyc=%0d data=%h expected 4 %h", cyc, res, ref_load(17'h00501, 3'b001));
    end
  endtask

  task automatic test_reset_mid;
    int cyc, lows, seen; logic [31:0] res; bit other;
    seen = 0;
    if_addr = 17'h00100; if_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({if_done, ma_done, if_inst, ma_rdata, mem_a, mem_dout, mem_wr} !== 93'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got if_inst=%h ma_rdata=%h mem_a=%h dout=%h wr=%b expected all zero",
               if_inst, ma_rdata, mem_a, mem_dout, mem_wr);
    end
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (8) begin @(negedge clk); if (if_done) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d pulses expected 0", seen); end
    run_op(0, 17'h00100, 3'b000, 32'd0, 32'd0, 1'b0, cyc, lows, res, other);
    checks++;
    if (cyc !== 6 || res !== ref_load(17'h00100, 3'b010)) begin
      errors++; $display("FAIL reset_mid_refetch: got cyc=%0d inst=%h expected 6 %h", cyc, res, ref_load(17'h00100, 3'b010));
    end
  endtask

  task automatic test_random;
    int cyc, lows, lat, kind; logic [31:0] res, expv, d, mask; bit other;
    logic [16:0] addr; logic [2:0] w;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 2);
      addr = ($urandom_range(0, 1) == 1 ? 17'h1FFF8 : 17'h00400) + 17'($urandom_range(0, 15));
      w    = 3'($urandom_range(0, 7));
      d    = $urandom;
      mask = ($urandom_range(0, 1) == 1) ? ($urandom & $urandom) : 32'd0;
      expv = (kind == 0) ? ref_load(addr, 3'b010) : ref_load(addr, w);
      lat  = (kind == 0) ? 6 : (kind == 1) ? nbytes(w) + 2 : nbytes(w) + 1;
      run_op(kind, addr, w, d, mask, 1'b0, cyc, lows, res, other);
      if (kind == 2) ref_store(addr, w, d);
      checks++;
      if (cyc !== lat + lows || other) begin
        errors++; $display("FAIL rand%0d_timing: got cyc=%0d other_done=%b expected cyc=%0d none (kind %0d)", n, cyc, other, lat + lows, kind);
      end
      if (kind != 2) begin
        checks++;
        if (res !== expv) begin
          errors++; $display("FAIL rand%0d_data: got %h expected %h (kind %0d addr %h w %0d)", n, res, expv, kind, addr, w);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_arbitration;
    test_store_wrap;
    test_rdy_pause;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
